// File: rtl/ntt_operand_issuer_if.sv
// ntt_operand_issuer_if
// ---------------------------------------------------------------------------
// Bundles every signal of the NTT operand issuer except clk/rst.
//   master : transform controller side (drives start/mode/en, observes rest)
//   slave  : the issuer itself
// Signals:
//   start, mode[1:0], en       control inputs to the issuer
//   busy, done                 transform progress
//   KD_mode, sel_0, sel_1      PE mode strobes
//   rd_en, rd_addr_a/b, tw_addr  read pair and twiddle address
//   wr_en, wr_addr_a/b         write-back pair (read side delayed PIPE_LAT)
//   state_dbg[1:0]             FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 FIN)
//   cycle_cnt[15:0]            only when ISSUER_PERF_CNT_EN is defined
//
// Handshake: start is a single-cycle request, honoured only while the issuer
// is idle and en=1; busy is high from the accepting edge until the done
// pulse. rd_en and wr_en are plain qualifiers for their address buses and
// have no back-pressure; en=0 stalls the whole block, including the
// write-back delay line.
// ---------------------------------------------------------------------------
interface ntt_operand_issuer_if #(
    parameter int ADDR_W = 7,
    parameter int TW_W   = 8
);
    logic              start;
    logic [1:0]        mode;
    logic              en;
    logic              busy;
    logic              done;
    logic              KD_mode;
    logic              sel_0;
    logic              sel_1;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [TW_W-1:0]   tw_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [1:0]        state_dbg;
`ifdef ISSUER_PERF_CNT_EN
    logic [15:0]       cycle_cnt;

    modport master (
        output start, mode, en,
        input  busy, done, KD_mode, sel_0, sel_1, rd_en, rd_addr_a, rd_addr_b,
               tw_addr, wr_en, wr_addr_a, wr_addr_b, state_dbg, cycle_cnt
    );
    modport slave (
        input  start, mode, en,
        output busy, done, KD_mode, sel_0, sel_1, rd_en, rd_addr_a, rd_addr_b,
               tw_addr, wr_en, wr_addr_a, wr_addr_b, state_dbg, cycle_cnt
    );
`else
    modport master (
        output start, mode, en,
        input  busy, done, KD_mode, sel_0, sel_1, rd_en, rd_addr_a, rd_addr_b,
               tw_addr, wr_en, wr_addr_a, wr_addr_b, state_dbg
    );
    modport slave (
        input  start, mode, en,
        output busy, done, KD_mode, sel_0, sel_1, rd_en, rd_addr_a, rd_addr_b,
               tw_addr, wr_en, wr_addr_a, wr_addr_b, state_dbg
    );
`endif
endinterface

// File: rtl/ntt_operand_issuer.sv
// ntt_operand_issuer
// ---------------------------------------------------------------------------
// Operand-side sequencer for the unified Kyber/Dilithium butterfly PE.
// Walks every NTT/INTT pass, issuing one word-pair read address, a twiddle
// ROM address and the PE mode strobes per enabled cycle, and replays the
// pair addresses as write-back addresses PIPE_LAT enabled cycles later.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (aborts a transform, no done)
//   bus  - ntt_operand_issuer_if.slave (control, read side, write side,
//          state_dbg)
// Optional: define ISSUER_PERF_CNT_EN to add bus.cycle_cnt, a saturating
// count of enabled busy cycles for the last/current transform.
// ---------------------------------------------------------------------------
module ntt_operand_issuer #(
    parameter int ADDR_W   = 7,
    parameter int PASSES_K = 4,
    parameter int PASSES_D = 7,
    parameter int PIPE_LAT = 4,
    parameter int TW_W     = 8
) (
    input logic                 clk,
    input logic                 rst,
    ntt_operand_issuer_if.slave bus
);
    localparam int KW = $clog2(ADDR_W + 1);  // holds pass, layer and shift
    localparam int DW = $clog2(PIPE_LAT) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-2:0] j_q, j_d;
    logic [DW-1:0]     cnt_q, cnt_d;

    // registered read side
    logic              rd_en_q, sel0_q;
    logic [ADDR_W-1:0] rd_a_q, rd_b_q;
    logic [TW_W-1:0]   tw_q;

    // write-back delay line
    logic              dl_en_q [PIPE_LAT];
    logic [ADDR_W-1:0] dl_a_q  [PIPE_LAT];
    logic [ADDR_W-1:0] dl_b_q  [PIPE_LAT];

    // address generation for the pair that will be presented next cycle
    logic [KW-1:0]     passes_d, lyr_d, sh_d;
    logic [ADDR_W-1:0] j_ext, grp_d, mask_d, addr_a_d, addr_b_d;
    logic [TW_W-1:0]   tw_d;
    logic              sel0_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    k_d     = '0;
                    j_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (&j_q) begin
                    state_d = DRAIN;
                    // DRAIN lasts PIPE_LAT cycles so the last write of this
                    // pass lands before the next pass reads.
                    cnt_d   = DW'(PIPE_LAT - 1);
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    if (k_q < passes_d - KW'(1)) begin
                        k_d     = k_q + KW'(1);
                        j_d     = '0;
                        state_d = ISSUE;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        passes_d = mode_d[1] ? KW'(PASSES_D) : KW'(PASSES_K);
        // INTT walks the layers in reverse order
        lyr_d    = mode_d[0] ? (passes_d - KW'(1) - k_d) : k_d;
        sh_d     = KW'(ADDR_W - 1) - lyr_d;      // log2(stride)
        j_ext    = {1'b0, j_d};
        grp_d    = j_ext >> sh_d;
        mask_d   = (ADDR_W'(1) << sh_d) - ADDR_W'(1);
        addr_a_d = (grp_d << (sh_d + KW'(1))) | (j_ext & mask_d);
        addr_b_d = addr_a_d + (ADDR_W'(1) << sh_d);
        tw_d     = (TW_W'(1) << lyr_d) + TW_W'(grp_d);
        sel0_d   = !mode_d[1] && (lyr_d != KW'(PASSES_K - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            sel0_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_en_q[i] <= 1'b0;
                dl_a_q[i]  <= '0;
                dl_b_q[i]  <= '0;
            end
        end else if (bus.en) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            // outside ISSUE only rd_en drops; addresses keep the last pair
            rd_en_q <= (state_d == ISSUE);
            if (state_d == ISSUE) begin
                sel0_q <= sel0_d;
                rd_a_q <= addr_a_d;
                rd_b_q <= addr_b_d;
                tw_q   <= tw_d;
            end
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                dl_en_q[i] <= dl_en_q[i-1];
                dl_a_q[i]  <= dl_a_q[i-1];
                dl_b_q[i]  <= dl_b_q[i-1];
            end
            dl_en_q[0] <= rd_en_q;
            dl_a_q[0]  <= rd_a_q;
            dl_b_q[0]  <= rd_b_q;
        end
    end

    assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done      = (state_q == FIN);
    assign bus.KD_mode   = mode_q[1];
    assign bus.sel_1     = mode_q[0];
    assign bus.sel_0     = sel0_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = dl_en_q[PIPE_LAT-1];
    assign bus.wr_addr_a = dl_a_q[PIPE_LAT-1];
    assign bus.wr_addr_b = dl_b_q[PIPE_LAT-1];
    assign bus.state_dbg = state_q;

`ifdef ISSUER_PERF_CNT_EN
    logic [15:0] cyc_q;

    // cleared on the accepting edge, then counts every non-idle cycle
    // including FIN, so it reads the full start-to-done cycle count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (bus.en) begin
            if (state_q == IDLE && state_d == ISSUE) begin
                cyc_q <= '0;
            end else if (state_q != IDLE && cyc_q != 16'hFFFF) begin
                cyc_q <= cyc_q + 16'd1;
            end
        end
    end

    assign bus.cycle_cnt = cyc_q;
`endif
endmodule

// File: tb/tb_ntt_operand_issuer.sv
module tb_ntt_operand_issuer;
  localparam int ADDR_W   = 7;
  localparam int TW_W     = 8;
  localparam int PIPE_LAT = 4;
  localparam int PAIRS    = 64;
  localparam int PK       = 4;
  localparam int PD       = 7;
  localparam int EW       = 1 + 2 * ADDR_W + TW_W;       // {sel_0, a, b, tw}
  localparam int HW       = 1 + 2 * ADDR_W;              // {en, a, b}
  localparam int OW       = 7 + 4 * ADDR_W + TW_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ntt_operand_issuer_if #(.ADDR_W(ADDR_W), .TW_W(TW_W)) bus ();

  ntt_operand_issuer #(
    .ADDR_W(ADDR_W), .PASSES_K(PK), .PASSES_D(PD), .PIPE_LAT(PIPE_LAT), .TW_W(TW_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];          // expected read pairs, in issue order
  logic [HW-1:0] hist_q[$];         // expected read side per enabled cycle
  logic          m_rd_en;
  logic [ADDR_W-1:0] m_a, m_b;      // model of held read addresses

  function automatic logic [OW-1:0] obs();
    return {bus.busy, bus.done, bus.KD_mode, bus.sel_0, bus.sel_1, bus.rd_en,
            bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
            bus.wr_en, bus.wr_addr_a, bus.wr_addr_b};
  endfunction

  // Transform as nested loops: per layer, groups of butterflies with
  // stride s, each group spanning 2*s words.
  function automatic void build_model(input logic [1:0] m);
    int p, lyr, s;
    logic s0;
    exp_q.delete();
    p = m[1] ? PD : PK;
    for (int k = 0; k < p; k++) begin
      lyr = m[0] ? (p - 1 - k) : k;
      s   = PAIRS >> lyr;
      s0  = (m[1] == 1'b0) && (lyr != PK - 1);
      for (int g = 0; g < (1 << lyr); g++) begin
        for (int o = 0; o < s; o++) begin
          exp_q.push_back({s0, ADDR_W'(g * 2 * s + o), ADDR_W'(g * 2 * s + o + s),
                           TW_W'((1 << lyr) + g)});
        end
      end
    end
  endfunction

  function automatic void reset_model();
    m_rd_en = 1'b0;
    m_a = '0;
    m_b = '0;
    hist_q.delete();
    for (int i = 0; i <= PIPE_LAT; i++) hist_q.push_back('0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one enabled idle cycle with write-side and idle checks
  task automatic idle_step(input string tag);
    logic [HW-1:0] eh;
    step();
    hist_q.push_back({1'b0, m_a, m_b});
    eh = hist_q[hist_q.size() - 1 - PIPE_LAT];
    while (hist_q.size() > PIPE_LAT + 1) void'(hist_q.pop_front());
    checks++;
    if ({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} !== eh) begin
      errors++;
      $display("FAIL %s_wr got %h exp %h", tag, {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b}, eh);
    end
    checks++;
    if ({bus.busy, bus.done, bus.rd_en} !== 3'b000) begin
      errors++;
      $display("FAIL %s_idle busy/done/rd_en got %b exp 000", tag, {bus.busy, bus.done, bus.rd_en});
    end
  endtask

  // Run one full transform. gap1/gap2: enabled-cycle index after which en
  // drops for 10 cycles (-1 = none). poke: assert start while busy and on
  // the done cycle.
  task automatic run_transform(input logic [1:0] m, input int gap1, input int gap2, input bit poke);
    int p, total, n, wall, gap_left, ngaps, issued, written, pass, q;
    logic exp_rd;
    logic [EW-1:0] e;
    logic [HW-1:0] eh;
    logic [OW-1:0] prev;
    p = m[1] ? PD : PK;
    total = p * (PAIRS + PIPE_LAT) + 1;
    n = 0; wall = 0; gap_left = 0; ngaps = 0; issued = 0; written = 0;
    build_model(m);
    bus.mode = m;
    bus.start = 1'b1;
    bus.en = 1'b1;
    prev = obs();
    while (n <= total && wall < 4000) begin
      step();
      wall++;
      if (bus.en) begin
        n++;
        pass = (n - 1) / (PAIRS + PIPE_LAT);
        q = (n - 1) % (PAIRS + PIPE_LAT);
        exp_rd = (n < total) && (q < PAIRS);
        checks++;
        if (bus.busy !== (n < total)) begin
          errors++;
          $display("FAIL busy m=%0d n=%0d got %b exp %b", m, n, bus.busy, (n < total));
        end
        checks++;
        if (bus.done !== (n == total)) begin
          errors++;
          $display("FAIL done m=%0d n=%0d got %b exp %b", m, n, bus.done, (n == total));
        end
        checks++;
        if (bus.rd_en !== exp_rd) begin
          errors++;
          $display("FAIL rd_en m=%0d n=%0d got %b exp %b", m, n, bus.rd_en, exp_rd);
        end
        if (n == total) begin
          checks++;
          if (wall != total + 10 * ngaps) begin
            errors++;
            $display("FAIL done_latency m=%0d got %0d exp %0d", m, wall, total + 10 * ngaps);
          end
        end
        // read side against the model
        m_rd_en = exp_rd;
        if (exp_rd) begin
          if (q == 0 && pass > 0) begin
            checks++;
            if (issued != written) begin
              errors++;
              $display("FAIL raw_overlap pass=%0d pending got %0d exp 0", pass, issued - written);
            end
          end
          issued++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL model_empty n=%0d got extra read exp none", n);
          end else begin
            e = exp_q.pop_front();
            m_a = e[TW_W + ADDR_W +: ADDR_W];
            m_b = e[TW_W +: ADDR_W];
            checks++;
            if ({bus.sel_0, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== e) begin
              errors++;
              $display("FAIL rd_pair m=%0d n=%0d got sel0=%b a=%0d b=%0d tw=%0d exp sel0=%b a=%0d b=%0d tw=%0d",
                       m, n, bus.sel_0, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                       e[EW-1], e[TW_W + ADDR_W +: ADDR_W], e[TW_W +: ADDR_W], e[TW_W-1:0]);
            end
            checks++;
            if ({bus.KD_mode, bus.sel_1} !== m) begin
              errors++;
              $display("FAIL mode_strobes n=%0d got %b exp %b", n, {bus.KD_mode, bus.sel_1}, m);
            end
          end
        end
        // write side: model read side delayed PIPE_LAT enabled cycles
        hist_q.push_back({m_rd_en, m_a, m_b});
        eh = hist_q[hist_q.size() - 1 - PIPE_LAT];
        while (hist_q.size() > PIPE_LAT + 1) void'(hist_q.pop_front());
        checks++;
        if ({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} !== eh) begin
          errors++;
          $display("FAIL wr_replay m=%0d n=%0d got %h exp %h", m, n,
                   {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b}, eh);
        end
        if (bus.wr_en) written++;
      end else begin
        checks++;
        if (obs() !== prev) begin
          errors++;
          $display("FAIL en_hold m=%0d n=%0d got %h exp %h", m, n, obs(), prev);
        end
      end
      prev = obs();
      // next-cycle stimulus
      if (gap_left > 0) gap_left--;
      else if (n == gap1 || n == gap2) begin
        gap_left = 10;
        ngaps++;
      end
      bus.en = (gap_left == 0);
      bus.start = poke && ((n < total) ? ($urandom_range(0, 3) == 0) : (n == total));
      if (poke) bus.mode = 2'($urandom_range(0, 3));
    end
    bus.start = 1'b0;
    checks++;
    if (n <= total) begin
      errors++;
      $display("FAIL timeout m=%0d got n=%0d exp %0d", m, n, total + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL model_left m=%0d got %0d exp 0", m, exp_q.size());
    end
`ifdef ISSUER_PERF_CNT_EN
    checks++;
    if (bus.cycle_cnt !== 16'(total)) begin
      errors++;
      $display("FAIL cycle_cnt m=%0d got %0d exp %0d", m, bus.cycle_cnt, total);
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0;
    bus.en = 1'b1;
    bus.mode = 2'b00;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({obs(), bus.state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {obs(), bus.state_dbg});
    end
    rst = 1'b0;
    reset_model();
    repeat (3) idle_step("post_reset");
  endtask

  task automatic test_k_ntt();
    run_transform(2'b00, -1, -1, 1'b0);
  endtask

  task automatic test_d_intt();
    run_transform(2'b11, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // each start lands in the cycle right after the previous done
    for (int r = 0; r < 2; r++) run_transform(2'($urandom_range(0, 3)), -1, -1, 1'b0);
  endtask

  task automatic test_en_stall();
    logic [1:0] m;
    int p, g1, g2, total;
    m = 2'($urandom_range(0, 3));
    p = m[1] ? PD : PK;
    g1 = $urandom_range(0, p - 1) * (PAIRS + PIPE_LAT) + $urandom_range(0, PAIRS - 2) + 1;
    g2 = $urandom_range(0, p - 1) * (PAIRS + PIPE_LAT) + $urandom_range(PAIRS, PAIRS + PIPE_LAT - 1) + 1;
    run_transform(m, g1, g2, 1'b0);
    // stall while done is asserted: it must hold
    m = 2'($urandom_range(0, 3));
    total = (m[1] ? PD : PK) * (PAIRS + PIPE_LAT) + 1;
    run_transform(m, total, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_transform(2'($urandom_range(0, 3)), -1, -1, 1'b1);
    idle_step("start_on_done");
  endtask

  task automatic test_reset_abort();
    int target;
    target = 2 * (PAIRS + PIPE_LAT) + $urandom_range(1, PAIRS - 1);
    bus.mode = 2'($urandom_range(0, 3));
    bus.start = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < target; i++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_early_done i=%0d got %b exp 0", i, bus.done);
      end
    end
    checks++;
    if ({bus.busy, bus.rd_en} !== 2'b11) begin
      errors++;
      $display("FAIL abort_midpass busy/rd_en got %b exp 11", {bus.busy, bus.rd_en});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({obs(), bus.state_dbg} !== '0) begin
      errors++;
      $display("FAIL abort_async got %h exp 0", {obs(), bus.state_dbg});
    end
    step();
    rst = 1'b0;
    checks++;
    if (obs() !== '0) begin
      errors++;
      $display("FAIL abort_held got %h exp 0", obs());
    end
`ifdef ISSUER_PERF_CNT_EN
    checks++;
    if (bus.cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_cycle_cnt got %0d exp 0", bus.cycle_cnt);
    end
`endif
    reset_model();
    repeat (6) idle_step("after_abort");
    run_transform(2'b00, -1, -1, 1'b0);
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_k_ntt();
    test_d_intt();
    test_back_to_back();
    test_en_stall();
    test_start_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
